split_tile_scheduler: RTL and testbench
=======================================

Name: split_tile_scheduler

Overview:
- Sits directly downstream of the split-tree generator. It consumes the split_type tile table once the generator reports ready, and issues every leaf tile to the systolic-array controller as one job.
- Jobs that start a K range (A_L_0 == 0) go out first with accumulate = 0. All partial-K leaves follow with accumulate = 1. This guarantees each output region is initialised before anything accumulates into it.
- Tracks job completions and reports done once all issued jobs have retired.

Parameters:
- OUT_SIZE, 64, number of entries in the tile table; must match the generator.
- IDX_W, 8, width of table indices and job counters.

Ports:
- clk  in  1  clock
- reset_n  in  1  reset
- start  in  1  one-cycle pulse, shared with the generator's start
- split_ready  in  1  generator table complete
- split_tab  in  split_type[OUT_SIZE]  tile table
- split_last  in  IDX_W  number of valid table entries
- job_valid  out  1  job offer
- job_ready  in  1  controller accepts job
- job_data  out  tile_job_t  {A/B/O bounds (12x10b), acc, src_idx}
- job_done  in  1  one-cycle pulse, one job retired
- busy  out  1  scheduler active
- done  out  1  one-cycle pulse, all jobs retired
- jobs_issued  out  IDX_W  jobs handshaken since start
- err  out  1  sticky; set by a job_done with no job outstanding

Behaviour:
- Reset is reset_n, synchronous, active-low; clock is clk.
  - Reset values: job_valid=0, job_data=0, busy=0, done=0, jobs_issued=0, err=0; state IDLE, all internal counters 0.
- FSM states: IDLE, WAIT_SPLIT, SCAN, ISSUE, DRAIN.
- start, any state:
  - Aborts current activity: job_valid=0, counters cleared, err cleared, pass=0, idx=0, busy=1.
  - Next state WAIT_SPLIT.
  - A job already offered but not accepted is withdrawn.
- WAIT_SPLIT:
  - split_ready is ignored in the cycle immediately after start, because the generator's ready clears one cycle late.
  - From the cycle after that, split_ready=1 latches n = min(split_last, OUT_SIZE) and moves to SCAN.
- SCAN (one table entry per cycle):
  - Entry idx is a leaf when to_n1==0 && to_n2==0.
  - Pass 0 qualifies: leaf && A_L_0==0. Pass 1 qualifies: leaf && A_L_0!=0.
  - Qualifying entry: load job_data (bounds copied verbatim, acc=pass, src_idx=idx), set job_valid=1 next cycle, go to ISSUE.
  - Non-qualifying entry: idx+1.
  - idx==n in pass 0: pass=1, idx=0.
  - idx==n in pass 1: go to DRAIN.
  - n==0: both passes end immediately and the block proceeds to DRAIN.
- ISSUE:
  - job_valid and job_data are held stable until job_ready is high.
  - On handshake: jobs_issued+1, idx+1, back to SCAN, job_valid=0 the next cycle.
  - Sustained rate is one job per 2 cycles at most; no combinational path from job_ready to job_valid.
- Completion counter cmpl:
  - Increments on job_done in any non-IDLE state, including the handshake cycle itself.
  - A job_done while cmpl==jobs_issued (counting the same-cycle handshake) is ignored and sets err.
- DRAIN:
  - When cmpl==jobs_issued: done=1 for one cycle, busy=0, state IDLE.
  - jobs_issued holds its value until the next start.
- Width rules: counters wrap modulo 2^IDX_W; OUT_SIZE ≤ 2^IDX_W-1 is required.
- job_done in IDLE is ignored and leaves err unchanged.

Decomposition:
- Shared package sys_array_pkg holds:
  - split_type (moved out of the generator's ifndef guard);
  - tile_job_t;
  - OUT_SIZE default;
  - IDX_W.
- One natural sub-module, split_leaf_sel: combinational leaf/pass qualification of one indexed entry. All sequencing stays in the top module.

Test Plan:
- Single tile: split_last=1, entry0 A=0..9/0..29, B=0..29/0..9, to_n*=0 → exactly one job (src_idx=0, acc=0); after job_done, done pulses; jobs_issued=1.
- K split: entry0 to_n1=1, to_n2=2; entry1 A_L 0..14; entry2 A_L 15..29; split_last=3 → jobs in order src 1 (acc=0) then src 2 (acc=1); entry0 never issued.
- Ordering across depths: K=0 leaf at idx 5, K=15 leaf at idx 3, split_last=7 → idx 5 issued before idx 3.
- Backpressure: job_ready low 3 cycles → job_valid and job_data stable all 3 cycles; exactly one handshake when job_ready rises.
- Completions: job_done arrives in the same cycle as the 2nd handshake → no err; an extra job_done afterwards sets err=1; done waits until cmpl==2.
- Abort and reset: start pulse while in ISSUE with job pending → job_valid=0 next cycle, counters 0, rescan after split_ready; reset_n low mid-DRAIN → all outputs at reset values next cycle.

Source files
------------

// File: rtl/sys_array_pkg.sv
// Types and sizing shared by the split-tree generator, the tile scheduler and the array controller.
package sys_array_pkg;

    localparam int unsigned OUT_SIZE_DEFAULT = 64;
    localparam int unsigned IDX_W            = 8;
    localparam int unsigned BND_W            = 10;

    typedef logic [BND_W-1:0] bnd_t;

    // Inclusive low/high bounds of the A, B and O operand windows, two dimensions each.
    typedef struct packed {
        bnd_t a_l_0;
        bnd_t a_h_0;
        bnd_t a_l_1;
        bnd_t a_h_1;
        bnd_t b_l_0;
        bnd_t b_h_0;
        bnd_t b_l_1;
        bnd_t b_h_1;
        bnd_t o_l_0;
        bnd_t o_h_0;
        bnd_t o_l_1;
        bnd_t o_h_1;
    } tile_bounds_t;

    // A node is a leaf when both child links are zero.
    typedef struct packed {
        tile_bounds_t     bnd;
        logic [IDX_W-1:0] to_n1;
        logic [IDX_W-1:0] to_n2;
    } split_type;

    typedef struct packed {
        tile_bounds_t     bnd;
        logic             acc;
        logic [IDX_W-1:0] src_idx;
    } tile_job_t;

endpackage

// File: rtl/split_tile_scheduler_if.sv
// Job channel between the tile scheduler (master) and the systolic-array controller (slave).
interface split_tile_scheduler_if;
    import sys_array_pkg::*;

    logic      job_valid;
    logic      job_ready;
    tile_job_t job_data;
    logic      job_done;

    modport master (
        output job_valid,
        output job_data,
        input  job_ready,
        input  job_done
    );

    modport slave (
        input  job_valid,
        input  job_data,
        output job_ready,
        output job_done
    );

endinterface

// File: rtl/split_leaf_sel.sv
// Selects one table entry by index and decides whether it is a leaf belonging to the current pass.
module split_leaf_sel
    import sys_array_pkg::*;
#(
    parameter int unsigned OUT_SIZE = OUT_SIZE_DEFAULT
) (
    input  split_type        split_tab [OUT_SIZE],
    input  logic [IDX_W-1:0] idx,
    input  logic             pass,
    output tile_bounds_t     bounds,
    output logic             qualify
);

    split_type entry;
    logic      leaf;
    logic      k_start;

    // Out-of-range indices read as zero; the scheduler never acts on them.
    always_comb begin
        entry = '0;
        for (int i = 0; i < int'(OUT_SIZE); i++) begin
            if (idx == IDX_W'(i)) begin
                entry = split_tab[i];
            end
        end
    end

    assign leaf    = (entry.to_n1 == '0) && (entry.to_n2 == '0);
    assign k_start = (entry.bnd.a_l_0 == '0);
    // Pass 0 takes K-range starters, pass 1 takes the partial-K remainder.
    assign qualify = leaf && (k_start ^ pass);
    assign bounds  = entry.bnd;

endmodule

// File: rtl/split_tile_scheduler.sv
// Issues every leaf of the split table as a job, K-starters first, then tracks completions.
module split_tile_scheduler
    import sys_array_pkg::*;
#(
    parameter int unsigned OUT_SIZE = OUT_SIZE_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic                   split_ready,
    input  split_type              split_tab [OUT_SIZE],
    input  logic [IDX_W-1:0]       split_last,
    split_tile_scheduler_if.master job,
    output logic                   busy,
    output logic                   done,
    output logic [IDX_W-1:0]       jobs_issued,
    output logic                   err
);

    localparam logic [2:0] StIdle      = 3'd0;
    localparam logic [2:0] StWaitSplit = 3'd1;
    localparam logic [2:0] StScan      = 3'd2;
    localparam logic [2:0] StIssue     = 3'd3;
    localparam logic [2:0] StDrain     = 3'd4;

    localparam logic [IDX_W-1:0] NMax = IDX_W'(OUT_SIZE);
    localparam logic [IDX_W-1:0] One  = IDX_W'(1);

    logic [2:0]       state_q, state_d;
    logic             pass_q, pass_d;
    logic             skip_q, skip_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] n_q, n_d;
    logic [IDX_W-1:0] cmpl_q, cmpl_d;
    logic [IDX_W-1:0] issued_q, issued_d;
    logic             valid_q, valid_d;
    tile_job_t        data_q, data_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    tile_bounds_t     sel_bounds;
    logic             sel_qualify;
    logic             handshake;
    logic [IDX_W-1:0] issued_eff;

    split_leaf_sel #(
        .OUT_SIZE (OUT_SIZE)
    ) u_leaf_sel (
        .split_tab (split_tab),
        .idx       (idx_q),
        .pass      (pass_q),
        .bounds    (sel_bounds),
        .qualify   (sel_qualify)
    );

    assign handshake  = (state_q == StIssue) && valid_q && job.job_ready;
    // A completion may legally retire the job handshaken in the same cycle.
    assign issued_eff = issued_q + {{(IDX_W-1){1'b0}}, handshake};

    always_comb begin
        state_d  = state_q;
        pass_d   = pass_q;
        skip_d   = skip_q;
        idx_d    = idx_q;
        n_d      = n_q;
        cmpl_d   = cmpl_q;
        issued_d = issued_q;
        valid_d  = valid_q;
        data_d   = data_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        err_d    = err_q;

        case (state_q)
            StWaitSplit: begin
                // The generator's ready deasserts one cycle late, so skip the first cycle.
                if (skip_q) begin
                    skip_d = 1'b0;
                end else if (split_ready) begin
                    n_d     = (split_last > NMax) ? NMax : split_last;
                    state_d = StScan;
                end
            end
            StScan: begin
                if (idx_q == n_q) begin
                    if (!pass_q) begin
                        pass_d = 1'b1;
                        idx_d  = '0;
                    end else begin
                        state_d = StDrain;
                    end
                end else if (sel_qualify) begin
                    data_d.bnd     = sel_bounds;
                    data_d.acc     = pass_q;
                    data_d.src_idx = idx_q;
                    valid_d        = 1'b1;
                    state_d        = StIssue;
                end else begin
                    idx_d = idx_q + One;
                end
            end
            StIssue: begin
                if (handshake) begin
                    issued_d = issued_q + One;
                    idx_d    = idx_q + One;
                    valid_d  = 1'b0;
                    state_d  = StScan;
                end
            end
            StDrain: begin
                if (cmpl_q == issued_q) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end
            end
            default: ;
        endcase

        if ((state_q != StIdle) && job.job_done) begin
            if (cmpl_q == issued_eff) begin
                err_d = 1'b1;
            end else begin
                cmpl_d = cmpl_q + One;
            end
        end

        // start overrides everything above, including a pending offer.
        if (start) begin
            state_d  = StWaitSplit;
            pass_d   = 1'b0;
            skip_d   = 1'b1;
            idx_d    = '0;
            n_d      = '0;
            cmpl_d   = '0;
            issued_d = '0;
            valid_d  = 1'b0;
            busy_d   = 1'b1;
            done_d   = 1'b0;
            err_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            pass_q   <= 1'b0;
            skip_q   <= 1'b0;
            idx_q    <= '0;
            n_q      <= '0;
            cmpl_q   <= '0;
            issued_q <= '0;
            valid_q  <= 1'b0;
            data_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pass_q   <= pass_d;
            skip_q   <= skip_d;
            idx_q    <= idx_d;
            n_q      <= n_d;
            cmpl_q   <= cmpl_d;
            issued_q <= issued_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign job.job_valid = valid_q;
    assign job.job_data  = data_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign jobs_issued   = issued_q;
    assign err           = err_q;

endmodule

// File: tb/tb_split_tile_scheduler.sv
// Directed bench for split_tile_scheduler; expected jobs go into a queue checked by a monitor.
module tb_split_tile_scheduler;
    import sys_array_pkg::*;

    localparam int unsigned N = OUT_SIZE_DEFAULT;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             start = 1'b0;
    logic             split_ready = 1'b0;
    logic [IDX_W-1:0] split_last = '0;
    split_type        tab [N];
    logic             busy;
    logic             done;
    logic [IDX_W-1:0] jobs_issued;
    logic             err;

    split_tile_scheduler_if jif ();

    tile_job_t exp_q[$];
    tile_job_t exp_job;
    tile_job_t held;
    int        errors = 0;
    int        checks = 0;

    always #5 clk = ~clk;

    split_tile_scheduler #(
        .OUT_SIZE (N)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .split_ready (split_ready),
        .split_tab   (tab),
        .split_last  (split_last),
        .job         (jif),
        .busy        (busy),
        .done        (done),
        .jobs_issued (jobs_issued),
        .err         (err)
    );

    // Every accepted job must match the head of the expected queue.
    always @(negedge clk) begin
        if (reset_n && jif.job_valid && jif.job_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL job_unexpected: got src=%0d acc=%0d, required no job",
                         jif.job_data.src_idx, jif.job_data.acc);
            end else begin
                exp_job = exp_q.pop_front();
                if (jif.job_data !== exp_job) begin
                    errors++;
                    $display("FAIL job_data: got src=%0d acc=%0d bnd=%h, required src=%0d acc=%0d bnd=%h",
                             jif.job_data.src_idx, jif.job_data.acc, jif.job_data.bnd,
                             exp_job.src_idx, exp_job.acc, exp_job.bnd);
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    function automatic tile_bounds_t mk_bnd(input int al0, input int ah0, input int al1,
                                            input int ah1);
        tile_bounds_t b;
        b.a_l_0 = 10'(al0);
        b.a_h_0 = 10'(ah0);
        b.a_l_1 = 10'(al1);
        b.a_h_1 = 10'(ah1);
        b.b_l_0 = 10'(al1);
        b.b_h_0 = 10'(ah1);
        b.b_l_1 = 10'(0);
        b.b_h_1 = 10'(9);
        b.o_l_0 = 10'(0);
        b.o_h_0 = 10'(9);
        b.o_l_1 = 10'(0);
        b.o_h_1 = 10'(9);
        return b;
    endfunction

    task automatic clear_tab();
        for (int i = 0; i < int'(N); i++) begin
            tab[i]       = '0;
            tab[i].to_n1 = IDX_W'(1);
        end
    endtask

    task automatic set_leaf(input int idx, input int al0, input int ah0);
        tab[idx].to_n1 = '0;
        tab[idx].to_n2 = '0;
        tab[idx].bnd   = mk_bnd(al0, ah0, 0, 29);
    endtask

    task automatic expect_job(input int idx, input logic acc);
        tile_job_t j;
        j.bnd     = tab[idx].bnd;
        j.acc     = acc;
        j.src_idx = IDX_W'(idx);
        exp_q.push_back(j);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_done();
        jif.job_done = 1'b1;
        tick();
        jif.job_done = 1'b0;
    endtask

    task automatic wait_issued(input int n, input string name);
        int k = 0;
        while (jobs_issued != IDX_W'(n) && k < 400) begin
            @(negedge clk);
            k++;
        end
        check(name, 64'(jobs_issued), 64'(n));
    endtask

    task automatic wait_valid(input string name);
        int k = 0;
        while (!jif.job_valid && k < 400) begin
            @(negedge clk);
            k++;
        end
        check(name, 64'(jif.job_valid), 64'(1));
    endtask

    task automatic wait_done(input string name);
        int   k = 0;
        logic seen = 1'b0;
        while (!seen && k < 400) begin
            @(negedge clk);
            if (done) seen = 1'b1;
            k++;
        end
        check(name, 64'(seen), 64'(1));
    endtask

    task automatic run_retire(input int n, input string name);
        wait_issued(n, {name, "_issued"});
        for (int i = 0; i < n; i++) pulse_done();
        wait_done({name, "_done"});
        check({name, "_jobs_issued"}, 64'(jobs_issued), 64'(n));
        check({name, "_err"}, 64'(err), 64'(0));
        check({name, "_busy"}, 64'(busy), 64'(0));
        check({name, "_queue_empty"}, 64'(exp_q.size()), 64'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        jif.job_ready = 1'b0;
        jif.job_done  = 1'b0;
        clear_tab();
        repeat (3) tick();
        check("rst_valid", 64'(jif.job_valid), 64'(0));
        check("rst_data_zero", 64'(jif.job_data == '0), 64'(1));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_jobs", 64'(jobs_issued), 64'(0));
        check("rst_err", 64'(err), 64'(0));
        reset_n = 1'b1;
        tick();

        // Single tile; split_ready is already high across start.
        clear_tab();
        set_leaf(0, 0, 9);
        split_last    = IDX_W'(1);
        split_ready   = 1'b1;
        jif.job_ready = 1'b1;
        expect_job(0, 1'b0);
        pulse_start();
        check("t1_busy", 64'(busy), 64'(1));
        run_retire(1, "t1");

        // K split: root never issued, K-start child before partial-K child.
        clear_tab();
        tab[0].to_n1 = IDX_W'(1);
        tab[0].to_n2 = IDX_W'(2);
        set_leaf(1, 0, 14);
        set_leaf(2, 15, 29);
        split_last = IDX_W'(3);
        expect_job(1, 1'b0);
        expect_job(2, 1'b1);
        pulse_start();
        run_retire(2, "t2");

        // Ordering across depths.
        clear_tab();
        set_leaf(5, 0, 9);
        set_leaf(3, 15, 29);
        split_last = IDX_W'(7);
        expect_job(5, 1'b0);
        expect_job(3, 1'b1);
        pulse_start();
        run_retire(2, "t3");

        // Empty table.
        clear_tab();
        set_leaf(0, 0, 9);
        split_last = '0;
        pulse_start();
        wait_done("t4_done");
        check("t4_jobs", 64'(jobs_issued), 64'(0));

        // split_last beyond the table clamps to OUT_SIZE; last entry still reachable.
        clear_tab();
        set_leaf(N - 1, 0, 9);
        split_last = IDX_W'(255);
        expect_job(N - 1, 1'b0);
        pulse_start();
        run_retire(1, "t5");

        // Backpressure.
        clear_tab();
        set_leaf(0, 0, 9);
        split_last    = IDX_W'(1);
        jif.job_ready = 1'b0;
        expect_job(0, 1'b0);
        pulse_start();
        wait_valid("t6_valid");
        held = jif.job_data;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t6_hold_valid", 64'(jif.job_valid), 64'(1));
            check("t6_hold_data", 64'(jif.job_data == held), 64'(1));
        end
        jif.job_ready = 1'b1;
        tick();
        check("t6_one_handshake", 64'(jobs_issued), 64'(1));
        check("t6_valid_drop", 64'(jif.job_valid), 64'(0));
        run_retire(1, "t6");

        // Completion counting.
        clear_tab();
        set_leaf(1, 0, 14);
        set_leaf(2, 15, 29);
        split_last    = IDX_W'(3);
        jif.job_ready = 1'b0;
        expect_job(1, 1'b0);
        expect_job(2, 1'b1);
        pulse_start();
        wait_valid("t7_valid1");
        tick();
        jif.job_ready = 1'b1;
        tick();
        jif.job_ready = 1'b0;
        check("t7_issued1", 64'(jobs_issued), 64'(1));
        wait_valid("t7_valid2");
        tick();
        jif.job_ready = 1'b1;
        jif.job_done  = 1'b1;
        tick();
        jif.job_ready = 1'b0;
        jif.job_done  = 1'b0;
        check("t7_same_cycle_no_err", 64'(err), 64'(0));
        check("t7_issued2", 64'(jobs_issued), 64'(2));
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check("t7_no_early_done", 64'(seen), 64'(0));
        check("t7_busy_drain", 64'(busy), 64'(1));
        pulse_done();
        wait_done("t7_done");
        check("t7_err_after", 64'(err), 64'(0));
        pulse_done();
        tick();
        check("t7_idle_done_ignored", 64'(err), 64'(0));
        pulse_start();
        pulse_done();
        check("t7_extra_done_err", 64'(err), 64'(1));

        // Abort while a job is offered, then rescan.
        wait_valid("t8_valid");
        pulse_start();
        check("t8_abort_valid", 64'(jif.job_valid), 64'(0));
        check("t8_abort_jobs", 64'(jobs_issued), 64'(0));
        check("t8_abort_err", 64'(err), 64'(0));
        check("t8_abort_busy", 64'(busy), 64'(1));
        expect_job(1, 1'b0);
        expect_job(2, 1'b1);
        jif.job_ready = 1'b1;
        run_retire(2, "t8");

        // Reset in the middle of DRAIN.
        clear_tab();
        set_leaf(0, 0, 9);
        split_last = IDX_W'(1);
        expect_job(0, 1'b0);
        pulse_start();
        wait_issued(1, "t9_issued");
        repeat (6) tick();
        check("t9_busy_drain", 64'(busy), 64'(1));
        reset_n = 1'b0;
        tick();
        check("t9_rst_valid", 64'(jif.job_valid), 64'(0));
        check("t9_rst_data_zero", 64'(jif.job_data == '0), 64'(1));
        check("t9_rst_busy", 64'(busy), 64'(0));
        check("t9_rst_done", 64'(done), 64'(0));
        check("t9_rst_jobs", 64'(jobs_issued), 64'(0));
        check("t9_rst_err", 64'(err), 64'(0));
        reset_n = 1'b1;
        tick();
        check("t9_queue_empty", 64'(exp_q.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
